axi_slave_write_ctrl: RTL

Slave-side AXI write responder for the course interconnect: accepts one write address (AW), the associated write-data burst (W), drives a word-addressed SRAM write port, and issues the write response (B) that the interconnect's B-channel arbiter collects and returns to the master. One transaction is in flight at a time. Instantiated once per writable slave (IM, DM, etc.) behind the interconnect's slave ports.

---
 rtl/axi_slave_write_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi_slave_write_ctrl.sv
// AXI write-slave responder: one AW + W burst at a time, drives a word SRAM
// write port and returns a single B response per transaction.
`timescale 1ns/1ps
module axi_slave_write_ctrl #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              incr_q, incr_d;
  logic              err_q, err_d;

  logic aw_hs;
  logic w_hs;
  logic last_beat;
  logic beat_err;
  logic unused_ok;

  assign unused_ok = ^{AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

  assign AWREADY = (state_q == IDLE);
  assign WREADY  = (state_q == DATA);
  assign BVALID  = (state_q == RESP);
  assign BID     = id_q;
  assign BRESP   = (BVALID && err_q) ? 2'b10 : 2'b00;

  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign last_beat = (cnt_q == len_q);

  // A WLAST mismatch poisons the beat it arrives on as well as later ones.
  assign beat_err  = err_q | (WLAST != last_beat);

  assign mem_we    = w_hs & ~beat_err;
  assign mem_addr  = ptr_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    incr_d  = incr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          ptr_d   = AWADDR[MEM_AW+1:2];
          len_d   = AWLEN;
          incr_d  = (AWBURST == 2'b01);
          cnt_d   = 4'd0;
          err_d   = (AWSIZE != 3'b010) | AWBURST[1];
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d = beat_err;
          if (incr_q) ptr_d = ptr_q + 1'b1;
          if (last_beat) state_d = RESP;
          else           cnt_d   = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      incr_q  <= incr_d;
      err_q   <= err_d;
    end
  end

endmodule
